data_mux_n: RTL and testbench
=============================

# data_mux_n

Parametrised, edge-triggered channel capture multiplexer for the serial link datapath. On a rising edge of the lock strobe it either latches one selected channel into a holding register, or scans every channel in turn and emits one word per cycle with an index tag. It sits between the measurement and register sources and the serial frame builder, which consumes `data_out` qualified by `out_valid`.

## Interface
- `WIDTH`, 16: bits per channel word.
- `N_CH`, 4: number of input channels; legal range 1 to 2^`SEL_W`.
- `SEL_W`, 8: width of `selector` and `out_index`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous active-high clear; takes priority over capture.
- `data_lock`  in  1  capture strobe; only its rising edge acts.
- `scan`  in  1  mode select, sampled on the lock edge: 0 = single capture, 1 = scan all channels.
- `selector`  in  `SEL_W`  channel to capture in single mode.
- `data_in`  in  `N_CH`*`WIDTH`  flattened channels; channel k occupies bits [k*`WIDTH` +: `WIDTH`].
- `data_out`  out  `WIDTH`  captured word (registered).
- `out_valid`  out  1  one-cycle pulse: `data_out` and `out_index` carry a new word.
- `out_index`  out  `SEL_W`  channel number of the current `data_out`.
- `out_last`  out  1  pulses with the final word of a scan, and with every single-mode capture.
- `busy`  out  1  high while a scan is in progress.
- `sel_err`  out  1  one-cycle pulse: single-mode selector is out of range.

## Operation
- Edge detection:
  - `pre_strb` registers `data_lock` every cycle, including during `clear`.
  - edge = `data_lock` & !`pre_strb`.
  - `pre_strb` resets to 0, so `data_lock` held high through reset release produces an edge on the first clock.
- States: IDLE and SCAN. `busy` = (state == SCAN).
- IDLE, edge, `scan`=0:
  - if `selector` < `N_CH`: load `data_out` with channel `selector`, set `out_index`=`selector`, pulse `out_valid` and `out_last`.
  - else: hold `data_out` and `out_index`, keep `out_valid`=0, pulse `sel_err`.
- IDLE, edge, `scan`=1:
  - capture channel 0 (`out_index`=0, pulse `out_valid`).
  - if `N_CH`=1, also pulse `out_last` and stay in IDLE.
  - otherwise load counter = 1 and go to SCAN.
  - `selector` is ignored.
- SCAN, each cycle:
  - capture channel `cnt` and pulse `out_valid` with `out_index`=`cnt`.
  - if `cnt`=`N_CH`-1: pulse `out_last`, clear the counter, return to IDLE.
  - else increment `cnt`.
  - Lock edges in SCAN are ignored (not queued). `pre_strb` still tracks, so a level held high does not re-trigger later.
- Without an event, `data_out` and `out_index` hold; `out_valid`, `out_last` and `sel_err` are 0.
- `clear`: `data_out`=0, `out_index`=0, all pulses 0, state IDLE, counter 0. Any scan is aborted with no `out_last`.
- Async reset (`reset_n`=0): `data_out`=0, `out_index`=0, `out_valid`=0, `out_last`=0, `busy`=0, `sel_err`=0, `pre_strb`=0, state IDLE, counter 0. It acts immediately, mid-scan included.
- Width rules:
  - counter width is `SEL_W`; the range compare is unsigned.
  - `out_index` is zero-extended channel number.

## Timing
- Edge sampled at clock E (`data_lock`=1, `pre_strb`=0). Channel data is sampled at that same edge E.
- Single mode: word visible after E, i.e. during cycle E+1, with 1-cycle latency. `sel_err` is also in cycle E+1.
- Scan mode:
  - channel k is sampled at clock E+k and visible in cycle E+k+1, for k = 0..`N_CH`-1.
  - `out_valid` is high for `N_CH` consecutive cycles, E+1..E+`N_CH`.
  - `out_last` is high in cycle E+`N_CH`.
  - `busy` is high in cycles E+1..E+`N_CH`-1, so it is never high when `N_CH`=1.
- Earliest accepted re-trigger: `data_lock` must go low and rise again. A rise sampled at clock E+`N_CH` or later starts a new capture.
- `clear` and an edge at the same clock: `clear` wins and the edge is consumed, not deferred.

## Test plan
- Reset, then single capture:
  - stimulus: `N_CH`=4, `WIDTH`=16, channels = 16'h1111/16'h2222/16'h3333/16'h4444, `selector`=2, one `data_lock` rise.
  - required: `data_out`=16'h3333, `out_index`=2, `out_valid`=1 and `out_last`=1 for exactly one cycle.
  - stimulus: `data_lock` held high 10 cycles.
  - required: no further `out_valid`.
- Out-of-range selector:
  - stimulus: `selector`=7 (`N_CH`=4) after the previous capture.
  - required: `sel_err` pulses once, `data_out` stays 16'h3333, `out_valid`=0.
- Scan:
  - stimulus: `scan`=1, one rise.
  - required: `out_valid` for 4 consecutive cycles with (`out_index`, `data_out`) = (0,1111), (1,2222), (2,3333), (3,4444); `out_last` only with index 3; `busy` high exactly 3 cycles.
- Retrigger during scan:
  - stimulus: second rise at E+2.
  - required: ignored, exactly 4 words total.
  - stimulus: rise at E+4.
  - required: a new scan starts, index 0 appears in cycle E+5.
- Abort:
  - stimulus: `clear` at E+2 of a scan.
  - required: next cycle `data_out`=0, `busy`=0, no `out_last`.
  - stimulus: `reset_n` low mid-scan, asynchronously between edges.
  - required: all outputs 0 before the next clock edge.
- Degenerate build:
  - stimulus: `N_CH`=1, scan rise.
  - required: one word with `out_valid`=`out_last`=1, index 0, `busy` never high.

Source files
------------

// File: rtl/data_mux_n.sv
// ---------------------------------------------------------------------------
// data_mux_n
//
// Channel capture multiplexer for the serial link datapath. A rising edge on
// data_lock either latches the channel chosen by selector (scan = 0) or walks
// every channel in order and emits one word per cycle with its index
// (scan = 1). The serial frame builder consumes data_out qualified by
// out_valid.
//
// Output handshake: there is no back-pressure. out_valid is a one-cycle
// pulse, and data_out / out_index are meaningful only in the cycle where it
// is high. The consumer must take the word in that cycle. Between events,
// data_out and out_index hold their last value.
//
// Parameters
//   WIDTH  bits per channel word
//   N_CH   number of channels, 1 .. 2**SEL_W
//   SEL_W  width of selector, out_index and the scan counter
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   clear      synchronous clear, wins over any capture in the same cycle
//   data_lock  capture strobe, only its rising edge acts
//   scan       0 = single capture, 1 = scan all channels (sampled on edge)
//   selector   channel to capture in single mode
//   data_in    flattened channels, channel k at [k*WIDTH +: WIDTH]
//   data_out   captured word (registered)
//   out_valid  pulse: data_out / out_index carry a new word
//   out_index  channel number of data_out (zero-extended)
//   out_last   pulse with the final scan word and every single capture
//   busy       high while a scan is in progress; this is the FSM state
//              itself (SCAN), so it doubles as the state debug view
//   sel_err    pulse: single-mode selector out of range
// ---------------------------------------------------------------------------
module data_mux_n #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4,
  parameter int SEL_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    data_lock,
  input  logic                    scan,
  input  logic [SEL_W-1:0]        selector,
  input  logic [N_CH*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    sel_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Compare in SEL_W+1 bits so N_CH = 2**SEL_W is representable.
  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  state_t             state;
  logic [SEL_W-1:0]   cnt;
  logic               pre_strb;

  logic               lock_edge;
  logic               sel_in_range;
  logic [SEL_W-1:0]   mux_idx;
  logic [WIDTH-1:0]   mux_word;

  assign lock_edge    = data_lock & ~pre_strb;
  assign sel_in_range = ({1'b0, selector} < N_CH_EXT);
  assign busy         = (state == SCAN);

  // Channel to sample this cycle: the scan counter while scanning, channel 0
  // when a scan starts, otherwise the selector.
  always_comb begin
    mux_idx = selector;
    if (state == SCAN) begin
      mux_idx = cnt;
    end else if (scan) begin
      mux_idx = '0;
    end
  end

  // Decoded mux; an out-of-range index yields zero but is never loaded.
  always_comb begin
    mux_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mux_idx == SEL_W'(k)) begin
        mux_word = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pre_strb  <= 1'b0;
      data_out  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      // The edge detector keeps tracking under clear and during a scan, so
      // an edge arriving then is consumed rather than deferred.
      pre_strb  <= data_lock;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sel_err   <= 1'b0;

      if (clear) begin
        state     <= IDLE;
        cnt       <= '0;
        data_out  <= '0;
        out_index <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (lock_edge) begin
              if (scan) begin
                data_out  <= mux_word;
                out_index <= '0;
                out_valid <= 1'b1;
                if (N_CH == 1) begin
                  out_last <= 1'b1;
                end else begin
                  cnt   <= SEL_W'(1);
                  state <= SCAN;
                end
              end else if (sel_in_range) begin
                data_out  <= mux_word;
                out_index <= selector;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
              end else begin
                sel_err <= 1'b1;
              end
            end
          end

          SCAN: begin
            data_out  <= mux_word;
            out_index <= cnt;
            out_valid <= 1'b1;
            if (cnt == LAST_CH) begin
              out_last <= 1'b1;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt + SEL_W'(1);
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mux_n.sv
// ---------------------------------------------------------------------------
// tb_data_mux_n
//
// Bench for data_mux_n. A four-channel instance is driven by directed
// sequences and then random stimulus, and compared every cycle against a
// queue-based reference model. A one-channel instance covers the degenerate
// build.
// ---------------------------------------------------------------------------
module tb_data_mux_n;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              clear;
  logic              data_lock;
  logic              scan;
  logic [SW-1:0]     selector;
  logic [N*W-1:0]    data_in;
  logic [W-1:0]      data_out;
  logic              out_valid;
  logic [SW-1:0]     out_index;
  logic              out_last;
  logic              busy;
  logic              sel_err;

  // one-channel instance
  logic              lock1;
  logic              scan1;
  logic [SW-1:0]     sel1;
  logic [W-1:0]      data_in1;
  logic [W-1:0]      d1_data;
  logic              d1_valid;
  logic [SW-1:0]     d1_index;
  logic              d1_last;
  logic              d1_busy;
  logic              d1_err;

  data_mux_n #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .data_lock (data_lock),
    .scan      (scan),
    .selector  (selector),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  data_mux_n #(.WIDTH(W), .N_CH(1), .SEL_W(SW)) u_one (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .data_lock (lock1),
    .scan      (scan1),
    .selector  (sel1),
    .data_in   (data_in1),
    .data_out  (d1_data),
    .out_valid (d1_valid),
    .out_index (d1_index),
    .out_last  (d1_last),
    .busy      (d1_busy),
    .sel_err   (d1_err)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;
  int n_busy  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A scan is a queue of channel numbers still to emit; one is popped per
  // clock. Emitted words also go to the scoreboard queue.
  logic [W-1:0]    m_data;
  logic [SW-1:0]   m_idx;
  logic            m_valid;
  logic            m_last;
  logic            m_err;
  logic            m_pre;
  int              scan_q[$];
  logic [24:0]     exp_q[$];   // {last, index, data}

  function automatic logic [W-1:0] chan(input int k);
    return data_in[k*W +: W];
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_idx   = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_err   = 1'b0;
    m_pre   = 1'b0;
    scan_q.delete();
    exp_q.delete();
  endtask

  task automatic emit(input int k, input logic last);
    m_data  = chan(k);
    m_idx   = SW'(k);
    m_valid = 1'b1;
    m_last  = last;
    exp_q.push_back({last, SW'(k), chan(k)});
  endtask

  task automatic model_step();
    int k;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_err   = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (clear) begin
      m_data = '0;
      m_idx  = '0;
      scan_q.delete();
    end else if (scan_q.size() != 0) begin
      k = scan_q.pop_front();
      emit(k, scan_q.size() == 0);
    end else if (data_lock && !m_pre) begin
      if (scan) begin
        for (int c = 0; c < N; c++) scan_q.push_back(c);
        k = scan_q.pop_front();
        emit(k, scan_q.size() == 0);
      end else if (int'(selector) < N) begin
        emit(int'(selector), 1'b1);
      end else begin
        m_err = 1'b1;
      end
    end
    m_pre = data_lock;
  endtask

  task automatic check_all();
    logic [24:0] front;
    check_eq("valid", out_valid, m_valid);
    check_eq("last",  out_last,  m_last);
    check_eq("err",   sel_err,   m_err);
    check_eq("busy",  busy,      scan_q.size() != 0);
    check_eq("data",  data_out,  m_data);
    check_eq("index", out_index, m_idx);
    if (out_valid) begin
      n_words++;
      if (exp_q.size() == 0) begin
        check_eq("sb_extra", out_valid, 1'b0);
      end else begin
        front = exp_q.pop_front();
        check_eq("sb_word", {out_last, out_index, data_out}, front);
      end
    end
    if (busy) n_busy++;
    check_eq("one_busy", d1_busy, 1'b0);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  int w0;
  int b0;

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    data_lock = 1'b0;
    scan      = 1'b0;
    selector  = '0;
    data_in   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    lock1     = 1'b0;
    scan1     = 1'b0;
    sel1      = '0;
    data_in1  = 16'hABCD;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_data",  data_out,  16'h0);
    check_eq("rst_index", out_index, 8'h0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_last",  out_last,  1'b0);
    check_eq("rst_busy",  busy,      1'b0);
    check_eq("rst_err",   sel_err,   1'b0);
    reset_n = 1'b1;
    tick();

    // single capture of channel 2
    selector  = 8'd2;
    data_lock = 1'b1;
    tick();
    check_eq("single_data",  data_out,  16'h3333);
    check_eq("single_index", out_index, 8'd2);
    check_eq("single_valid", out_valid, 1'b1);
    check_eq("single_last",  out_last,  1'b1);
    w0 = n_words;
    repeat (10) tick();
    check_eq("hold_no_retrigger", n_words - w0, 0);
    data_lock = 1'b0;
    tick();

    // out-of-range selector
    selector  = 8'd7;
    data_lock = 1'b1;
    tick();
    check_eq("oor_err",   sel_err,   1'b1);
    check_eq("oor_data",  data_out,  16'h3333);
    check_eq("oor_valid", out_valid, 1'b0);
    data_lock = 1'b0;
    tick();
    check_eq("oor_err_once", sel_err, 1'b0);

    // full scan
    scan      = 1'b1;
    data_lock = 1'b1;
    w0 = n_words;
    b0 = n_busy;
    tick();
    check_eq("scan_first_index", out_index, 8'd0);
    check_eq("scan_first_data",  data_out,  16'h1111);
    data_lock = 1'b0;
    repeat (3) tick();
    check_eq("scan_last_index", out_index, 8'd3);
    check_eq("scan_last_data",  data_out,  16'h4444);
    check_eq("scan_last_flag",  out_last,  1'b1);
    tick();
    check_eq("scan_words", n_words - w0, 4);
    check_eq("scan_busy_cycles", n_busy - b0, 3);

    // retrigger inside a scan is ignored; at E+4 it starts a new one
    data_lock = 1'b1;
    w0 = n_words;
    tick();                   // edge at E
    data_lock = 1'b0;
    tick();                   // E+1
    data_lock = 1'b1;
    tick();                   // rise at E+2, ignored
    data_lock = 1'b0;
    tick();                   // E+3, now in cycle E+4
    check_eq("retrig_ignored_words", n_words - w0, 4);
    data_lock = 1'b1;
    tick();                   // rise at E+4, now in cycle E+5
    check_eq("retrig_valid", out_valid, 1'b1);
    check_eq("retrig_index", out_index, 8'd0);
    data_lock = 1'b0;
    repeat (4) tick();

    // clear aborts a scan
    data_lock = 1'b1;
    tick();
    data_lock = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    check_eq("clear_data", data_out, 16'h0);
    check_eq("clear_busy", busy,     1'b0);
    check_eq("clear_last", out_last, 1'b0);
    clear = 1'b0;
    repeat (2) tick();

    // asynchronous reset in the middle of a scan
    data_lock = 1'b1;
    tick();
    data_lock = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_data",  data_out,  16'h0);
    check_eq("arst_index", out_index, 8'h0);
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_last",  out_last,  1'b0);
    check_eq("arst_busy",  busy,      1'b0);
    check_eq("arst_err",   sel_err,   1'b0);
    model_reset();
    // lock held high through reset release is an edge on the first clock
    scan      = 1'b0;
    selector  = 8'd1;
    data_lock = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("rst_release_valid", out_valid, 1'b1);
    check_eq("rst_release_data",  data_out,  16'h2222);
    data_lock = 1'b0;
    tick();

    // random phase
    for (int i = 0; i < 600; i++) begin
      data_in   = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) data_lock = ~data_lock;
      scan      = 1'($urandom_range(0, 1));
      selector  = SW'($urandom_range(0, 7));
      clear     = ($urandom_range(0, 24) == 0);
      tick();
    end
    clear     = 1'b0;
    data_lock = 1'b0;
    repeat (6) tick();
    check_eq("sb_drain", exp_q.size(), 0);

    // one-channel build
    scan1 = 1'b1;
    lock1 = 1'b1;
    tick();
    check_eq("one_valid", d1_valid, 1'b1);
    check_eq("one_last",  d1_last,  1'b1);
    check_eq("one_index", d1_index, 8'd0);
    check_eq("one_data",  d1_data,  16'hABCD);
    lock1 = 1'b0;
    tick();
    check_eq("one_valid_end", d1_valid, 1'b0);
    scan1 = 1'b0;
    sel1  = 8'd1;
    lock1 = 1'b1;
    tick();
    check_eq("one_oor_err",   d1_err,   1'b1);
    check_eq("one_oor_valid", d1_valid, 1'b0);
    lock1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
